// File: rtl/ms_channel_sequencer_pkg.sv
// Shared types for the channel sequencer: section encoding and miss-counter width.
package ms_channel_sequencer_types;

  localparam int MISS_CNT_W = 16;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    COMBINE = 2'd1,
    EMIT    = 2'd2
  } section_e;

endpackage

// File: rtl/ms_channel_sequencer_rr_pointer.sv
// Round-robin channel pointer; steps on advance and wraps from NUM_CH-1 to 0.
module ms_rr_pointer #(
  parameter int NUM_CH = 4,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ms_channel_sequencer.sv
// Round-robin channel sequencer: capture one channel, add shared_in, emit result.
// Optional 16-bit saturating miss counter enabled by defining MS_SEQ_MISS_CNT_EN.
//
// state   | meaning
// SCAN    | test sync of the pointed channel; capture it or move to the next
// COMBINE | add shared_in to the captured value
// EMIT    | publish result with its channel index, pulse s_out_upd, advance
module ms_channel_sequencer
  import ms_channel_sequencer_types::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   s_in,
  input  logic [NUM_CH-1:0]          s_in_sync,
  input  logic [DATA_W-1:0]          shared_in,
  output logic [DATA_W-1:0]          s_out,
  output logic [$clog2(NUM_CH)-1:0]  s_out_ch,
`ifdef MS_SEQ_MISS_CNT_EN
  output logic [MISS_CNT_W-1:0]      miss_cnt,
`endif
  output logic                       s_out_upd
);

  localparam int PTR_W = $clog2(NUM_CH);

  section_e           section;
  logic [PTR_W-1:0]   ptr;
  logic [DATA_W-1:0]  val;
  logic [DATA_W-1:0]  shared;
  logic               succ;
  logic               cur_sync;
  logic [DATA_W-1:0]  cur_data;
  logic               advance;

  assign cur_sync = s_in_sync[ptr];
  assign cur_data = s_in[int'(ptr)*DATA_W +: DATA_W];
  assign advance  = ((section == SCAN) && !cur_sync) || (section == EMIT);

  ms_rr_pointer #(.NUM_CH(NUM_CH)) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .ptr     (ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section   <= SCAN;
      val       <= '0;
      shared    <= '0;
      succ      <= 1'b0;
      s_out     <= '0;
      s_out_ch  <= '0;
      s_out_upd <= 1'b0;
    end else begin
      s_out_upd <= 1'b0;
      case (section)
        SCAN: begin
          if (cur_sync) begin
            val     <= cur_data;
            succ    <= 1'b1;
            section <= COMBINE;
          end else begin
            succ    <= 1'b0;
          end
        end
        COMBINE: begin
          shared  <= val + shared_in;
          section <= EMIT;
        end
        EMIT: begin
          // succ is always set on entry here; a reset clears it with the value
          s_out     <= shared;
          s_out_ch  <= ptr;
          s_out_upd <= succ;
          section   <= SCAN;
        end
        default: section <= SCAN;
      endcase
    end
  end

`ifdef MS_SEQ_MISS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if ((section == SCAN) && !cur_sync && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ms_channel_sequencer.sv
// Directed bench for ms_channel_sequencer (NUM_CH=4, DATA_W=32); miss_cnt checked when MS_SEQ_MISS_CNT_EN is set.
module tb_ms_channel_sequencer;

  logic           clk;
  logic           rst;
  logic [127:0]   s_in;
  logic [3:0]     s_in_sync;
  logic [31:0]    shared_in;
  logic [31:0]    s_out;
  logic [1:0]     s_out_ch;
  logic           s_out_upd;
`ifdef MS_SEQ_MISS_CNT_EN
  logic [15:0]    miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ms_channel_sequencer #(.NUM_CH(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_in      (s_in),
    .s_in_sync (s_in_sync),
    .shared_in (shared_in),
    .s_out     (s_out),
    .s_out_ch  (s_out_ch),
`ifdef MS_SEQ_MISS_CNT_EN
    .miss_cnt  (miss_cnt),
`endif
    .s_out_upd (s_out_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] v, input logic [1:0] ch, input logic upd);
    check({tag, "_s_out"}, s_out, v);
    check({tag, "_ch"}, {30'd0, s_out_ch}, {30'd0, ch});
    check({tag, "_upd"}, {31'd0, s_out_upd}, {31'd0, upd});
  endtask

  logic [31:0] fair_val [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
  logic [1:0]  fair_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1;
    s_in = '0;
    s_in_sync = '0;
    shared_in = '0;

    // reset state
    step();
    check_out("reset", 32'd0, 2'd0, 1'b0);
`ifdef MS_SEQ_MISS_CNT_EN
    check("reset_miss", {16'd0, miss_cnt}, 32'd0);
`endif

    // single capture, with sync dropped while in flight
    rst = 1'b0;
    s_in[31:0] = 32'd5;
    shared_in = 32'd10;
    s_in_sync = 4'b0001;
    step();
    s_in_sync = 4'b0000;
    check("single_e0_upd", {31'd0, s_out_upd}, 32'd0);
    step();
    check("single_e1_upd", {31'd0, s_out_upd}, 32'd0);
    step();
    check_out("single", 32'd15, 2'd0, 1'b1);
    step();
    check_out("single_hold", 32'd15, 2'd0, 1'b0);

    // asynchronous reset mid-clock
    #3;
    rst = 1'b1;
    #1;
    check_out("async_rst", 32'd0, 2'd0, 1'b0);
`ifdef MS_SEQ_MISS_CNT_EN
    check("async_rst_miss", {16'd0, miss_cnt}, 32'd0);
`endif
    step();

    // scan skip: only channel 2 valid
    rst = 1'b0;
    s_in[95:64] = 32'd7;
    shared_in = 32'd3;
    s_in_sync = 4'b0100;
    step();
    step();
`ifdef MS_SEQ_MISS_CNT_EN
    check("skip_miss", {16'd0, miss_cnt}, 32'd2);
`endif
    check("skip_upd0", {31'd0, s_out_upd}, 32'd0);
    step();
    step();
    check("skip_upd1", {31'd0, s_out_upd}, 32'd0);
    step();
    check_out("skip", 32'd10, 2'd2, 1'b1);

    // fairness with all syncs high
    s_in_sync = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) s_in[i*32 +: 32] = 32'(i + 1);
    shared_in = 32'd0;
    s_in_sync = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      step();
      check($sformatf("fair%0d_pre_upd", k), {31'd0, s_out_upd}, 32'd0);
      step();
      check_out($sformatf("fair%0d", k), fair_val[k], fair_ch[k], 1'b1);
    end

    // modulo-2^32 addition
    s_in_sync = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_in[31:0] = 32'hFFFF_FFFF;
    shared_in = 32'd2;
    s_in_sync = 4'b0001;
    step();
    step();
    step();
    check_out("wrap", 32'd1, 2'd0, 1'b1);

    // reset while in COMBINE, then restart from channel 0
    s_in[31:0] = 32'd20;
    s_in[63:32] = 32'd9;
    shared_in = 32'd1;
    s_in_sync = 4'b0010;
    step();
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_comb", 32'd0, 2'd0, 1'b0);
    step();
    check_out("rst_comb_hold", 32'd0, 2'd0, 1'b0);
    rst = 1'b0;
    s_in_sync = 4'b0011;
    step();
    check("restart_e0_upd", {31'd0, s_out_upd}, 32'd0);
    step();
    check("restart_e1_upd", {31'd0, s_out_upd}, 32'd0);
    step();
    check_out("restart", 32'd21, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
